// File: rtl/reg_pipe_vr.sv
// Parametrised valid/ready register chain with bubble collapsing, synchronous flush
// and an occupancy count derived only from the stage valid bits.
module reg_pipe_vr #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 2,
  parameter logic [DATA_WIDTH-1:0] RST_VALUE = '0
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_flush,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic [DATA_WIDTH-1:0]        i_data,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [DATA_WIDTH-1:0]        o_data,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH+1);

  logic [DEPTH-1:0]      v;
  logic [DEPTH-1:0]      v_nxt;
  logic [DEPTH-1:0]      in_v;
  logic [DEPTH-1:0]      xfer;
  logic [DEPTH:0]        r;
  logic [DATA_WIDTH-1:0] d    [DEPTH];
  logic [DATA_WIDTH-1:0] d_in [DEPTH];
  logic [CW-1:0]         count_c;

  // r[k] is true when any stage at or beyond k is empty, or downstream accepts.
  // Built with a running accumulator so r never reads back its own bits.
  always_comb begin : ready_chain
    logic acc;
    acc = i_ready;
    r = '0;
    r[DEPTH] = i_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      acc = acc || !v[k];
      r[k] = acc;
    end
  end

  always_comb begin
    in_v = '0;
    in_v[0] = i_valid && !i_flush;
    for (int k = 1; k < DEPTH; k++) begin
      in_v[k] = v[k-1];
    end
    xfer = in_v & r[DEPTH-1:0];
    v_nxt = i_flush ? '0 : (xfer | (v & ~r[DEPTH:1]));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      v <= '0;
    end else begin
      v <= v_nxt;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign d_in[k] = i_data;
    end else begin : g_next
      assign d_in[k] = d[k-1];
    end

    // Data registers are enable-only; a flush leaves them as don't-care.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        d[k] <= RST_VALUE;
      end else if (xfer[k]) begin
        d[k] <= d_in[k];
      end
    end
  end

  always_comb begin
    count_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      count_c = count_c + CW'(v[k]);
    end
  end

  assign o_ready = r[0] && !i_flush;
  assign o_valid = v[DEPTH-1];
  assign o_data  = d[DEPTH-1];
  assign o_count = count_c;

endmodule
